fib_seq_ctrl: RTL
=================

FIB_SEQ_CTRL -- requirements
Module: fib_seq_ctrl

Interface
REQ-001 SHALL have parameter POS_W, default 9, Fibonacci index width.
REQ-002 SHALL have parameter DATA_W, default 16, result width.
REQ-003 SHALL have parameter MAX_POS, default 24, largest index whose result fits DATA_W.
REQ-004 SHALL have parameter TIMEOUT, default 1023, engine watchdog limit in cycles.
REQ-005 SHALL have port clk  input  1  single clock, rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port req_valid  input  1  host request present.
REQ-008 SHALL have port req_pos  input  POS_W  requested index n.
REQ-009 SHALL have port req_ready  output  1  controller can accept.
REQ-010 SHALL have port FIB  output  1  engine run level.
REQ-011 SHALL have port pos  output  POS_W  index driven to engine.
REQ-012 SHALL have port FIB_END  input  1  engine completion.
REQ-013 SHALL have port fib_result  input  DATA_W  engine result (F3 register value).
REQ-014 SHALL have port rsp_valid  output  1  response present.
REQ-015 SHALL have port rsp_data  output  DATA_W  F(n).
REQ-016 SHALL have port rsp_err  output  1  request rejected or aborted.
REQ-017 SHALL have port rsp_ready  input  1  host takes response.

Function
REQ-018 SHALL implement FSM states IDLE, RUN, RESP; the convention is F(0)=0, F(1)=1.
REQ-019 SHALL drive req_ready=1 only in IDLE; a request is accepted on req_valid&req_ready.
REQ-020 SHALL, on accept, latch req_pos into pos; pos is held stable until the next accept.
REQ-021 SHALL, on accept with req_pos==0, go to RESP with rsp_data=0, rsp_err=0, FIB never asserted.
REQ-022 SHALL, on accept with req_pos>MAX_POS, go to RESP with rsp_data=0, rsp_err=1, FIB never asserted.
REQ-023 SHALL, on any other accept, go to RUN; FIB is registered high from the cycle after accept through the RUN exit cycle.
REQ-024 SHALL, in RUN with FIB_END=1, capture fib_result into rsp_data with rsp_err=0, deassert FIB next cycle, and enter RESP.
REQ-025 SHALL hold rsp_valid=1 with stable rsp_data/rsp_err throughout RESP until rsp_ready=1, then return to IDLE next cycle.
REQ-026 SHALL NOT accept a new request in the same cycle that a response is consumed; earliest accept is one cycle later.
REQ-027 SHALL ignore FIB_END outside RUN.
REQ-028 SHALL ignore req_valid/req_pos changes while not in IDLE.
REQ-029 SHALL give latency accept->rsp_valid of one cycle for rejected and n=0 requests, and engine cycles plus one otherwise.

Reset
REQ-030 SHALL, while rst=0, force state IDLE, FIB=0, pos=0, rsp_valid=0, rsp_data=0, rsp_err=0, watchdog count 0, independent of clk.
REQ-031 SHALL, on reset mid-RUN, drop FIB immediately and discard the in-flight request without a response.

Configuration
REQ-032 SHALL compile a RUN-state watchdog only when macro FIB_SEQ_TIMEOUT_EN is defined.
REQ-033 SHALL, with FIB_SEQ_TIMEOUT_EN defined, count RUN cycles; if TIMEOUT cycles elapse without FIB_END, it drops FIB and enters RESP with rsp_data=0, rsp_err=1; FIB_END on the limit cycle wins.
REQ-034 SHALL, without FIB_SEQ_TIMEOUT_EN, remain in RUN indefinitely until FIB_END and contain no watchdog logic.

Structure
REQ-035 SHALL take its state encoding, the default widths and the MAX_POS/TIMEOUT defaults from shared package fib_pkg.
REQ-036 SHALL place the watchdog in sub-module fib_wdog (clear, enable, expired), instantiated only under FIB_SEQ_TIMEOUT_EN.

Verification
REQ-037 SHALL cover: req_pos=10, engine model -> FIB high until FIB_END, rsp_data=55, rsp_err=0.
REQ-038 SHALL cover: req_pos=0 -> rsp_valid one cycle after accept, rsp_data=0, FIB stays 0.
REQ-039 SHALL cover: req_pos=25 and req_pos=24 -> first gives rsp_err=1, FIB stays 0; second gives rsp_data=46368.
REQ-040 SHALL cover: rsp_ready held 0 for 5 cycles, req_valid high -> response stable, req_ready=0, and accept occurs one cycle after the rsp_ready handshake.
REQ-041 SHALL cover: rst pulsed low mid-RUN -> FIB=0 asynchronously, rsp_valid=0, and the next request completes normally.
REQ-042 SHALL cover, with FIB_SEQ_TIMEOUT_EN and TIMEOUT=8, an engine that never asserts FIB_END -> after 8 RUN cycles rsp_err=1, rsp_data=0, FIB=0.

Source files
------------

// File: rtl/fib_pkg.sv
// Shared types and default sizing for the Fibonacci sequencing controller.
// The watchdog (macro FIB_SEQ_TIMEOUT_EN) uses FIB_TIMEOUT as its default limit.
package fib_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_RESP = 2'd2
  } fib_state_t;

  localparam int FIB_POS_W   = 9;
  localparam int FIB_DATA_W  = 16;
  // F(24) = 46368 is the largest term that fits in 16 bits.
  localparam int FIB_MAX_POS = 24;
  localparam int FIB_TIMEOUT = 1023;

endpackage

// File: rtl/fib_wdog.sv
// RUN-state watchdog: counts enabled cycles since clear and flags the LIMIT-th one.
// Only instantiated when FIB_SEQ_TIMEOUT_EN is defined.
module fib_wdog
  import fib_pkg::*;
#(
  parameter int LIMIT = FIB_TIMEOUT
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (clear) begin
      cnt_reg <= '0;
    end else if (enable && (cnt_reg != LAST)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  // The count holds the number of RUN cycles already completed, so LAST marks the final one.
  assign expired = enable && (cnt_reg == LAST);

endmodule

// File: rtl/fib_seq_ctrl.sv
// Request/response controller that sequences an external Fibonacci engine.
// Define FIB_SEQ_TIMEOUT_EN to add a RUN-state watchdog (fib_wdog).
module fib_seq_ctrl
  import fib_pkg::*;
#(
  parameter int POS_W   = FIB_POS_W,
  parameter int DATA_W  = FIB_DATA_W,
  parameter int MAX_POS = FIB_MAX_POS,
  parameter int TIMEOUT = FIB_TIMEOUT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  input  logic [POS_W-1:0]  req_pos,
  output logic              req_ready,
  output logic              FIB,
  output logic [POS_W-1:0]  pos,
  input  logic              FIB_END,
  input  logic [DATA_W-1:0] fib_result,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  input  logic              rsp_ready
);

  localparam logic [POS_W-1:0] MAX_POS_V = POS_W'(MAX_POS);

  if (MAX_POS >= (1 << POS_W) || TIMEOUT < 1) begin : g_cfg_check
    $error("fib_seq_ctrl: MAX_POS must fit POS_W and TIMEOUT must be at least 1");
  end

  fib_state_t        state_reg;
  logic              fib_reg;
  logic [POS_W-1:0]  pos_reg;
  logic              rsp_valid_reg;
  logic [DATA_W-1:0] rsp_data_reg;
  logic              rsp_err_reg;
  logic              accept;

  assign req_ready = (state_reg == ST_IDLE);
  assign accept    = req_valid && req_ready;

`ifdef FIB_SEQ_TIMEOUT_EN
  logic wd_expired;

  fib_wdog #(
    .LIMIT (TIMEOUT)
  ) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .enable  (state_reg == ST_RUN),
    .expired (wd_expired)
  );
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg     <= ST_IDLE;
      fib_reg       <= 1'b0;
      pos_reg       <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_data_reg  <= '0;
      rsp_err_reg   <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            pos_reg <= req_pos;
            // n=0 and out-of-range indices are answered without starting the engine.
            if (req_pos == '0) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_data_reg  <= '0;
              rsp_err_reg   <= 1'b0;
            end else if (req_pos > MAX_POS_V) begin
              state_reg     <= ST_RESP;
              rsp_valid_reg <= 1'b1;
              rsp_data_reg  <= '0;
              rsp_err_reg   <= 1'b1;
            end else begin
              state_reg <= ST_RUN;
              fib_reg   <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (FIB_END) begin
            state_reg     <= ST_RESP;
            fib_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= fib_result;
            rsp_err_reg   <= 1'b0;
          end
`ifdef FIB_SEQ_TIMEOUT_EN
          else if (wd_expired) begin
            state_reg     <= ST_RESP;
            fib_reg       <= 1'b0;
            rsp_valid_reg <= 1'b1;
            rsp_data_reg  <= '0;
            rsp_err_reg   <= 1'b1;
          end
`endif
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state_reg     <= ST_IDLE;
            rsp_valid_reg <= 1'b0;
          end
        end
        default: begin
          state_reg <= ST_IDLE;
          fib_reg   <= 1'b0;
        end
      endcase
    end
  end

  assign FIB       = fib_reg;
  assign pos       = pos_reg;
  assign rsp_valid = rsp_valid_reg;
  assign rsp_data  = rsp_data_reg;
  assign rsp_err   = rsp_err_reg;

endmodule
